usb_ep_proto_ctrl: RTL and testbench

- Endpoint protocol controller that sequences the USB receiver and transmitter for a single bulk endpoint.
- Consumes decoded packet events from the RX block (packet ID, data-ready, error, occupancy) and tracks the DATA0/DATA1 toggle.
- Decides the ACK/NAK or DATA response, schedules the TX block, and arbitrates bus direction (d_mode).
- Sits between usb_rx, usb_tx and the host-side buffer logic.

---
 rtl/usb_proto_pkg.sv | 25 ++
 rtl/usb_timeout_counter.sv | 19 +
 rtl/usb_ep_proto_ctrl.sv | 142 ++++++++++++++
 tb/tb_usb_ep_proto_ctrl.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usb_proto_pkg.sv
// usb_proto_pkg: shared USB PID encoding, endpoint FSM states and packet constants.
package usb_proto_pkg;
  typedef enum logic [2:0] {
    PID_NONE  = 3'd0,
    PID_OUT   = 3'd1,
    PID_IN    = 3'd2,
    PID_DATA0 = 3'd3,
    PID_DATA1 = 3'd4,
    PID_ACK   = 3'd5,
    PID_NAK   = 3'd6,
    PID_STALL = 3'd7
  } pid_t;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_OUT_WAIT,
    ST_HS_SEND,
    ST_IN_SEND,
    ST_TX_BUSY,
    ST_IN_WAIT
  } state_t;
  localparam int MAX_PKT = 64;
  function automatic logic is_data(input logic [2:0] p);
    return (p == PID_DATA0) || (p == PID_DATA1);
  endfunction
endpackage

// File: rtl/usb_timeout_counter.sv
// usb_timeout_counter: saturating cycle counter, i_clr wins over i_en, o_done at TIMEOUT_CYC-1.
// Ports: clk, n_rst (async active-low), i_clr, i_en, o_done.
module usb_timeout_counter #(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TMR_W       = 11
) (
  input  logic clk,
  input  logic n_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);
  logic [TMR_W-1:0] r_cnt;
  assign o_done = r_cnt == TMR_W'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge n_rst)
    if (!n_rst) r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en && !o_done) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/usb_ep_proto_ctrl.sv
// usb_ep_proto_ctrl: bulk endpoint protocol sequencer (handshake, data toggle, TX scheduling, d_mode).
// Inputs : clk, n_rst, rx_packet, rx_data_ready, rx_error, buffer_ocup, in_data_valid, tx_transfer_active
// Outputs: tx_packet, tx_start, d_mode, flush_req, rx_ok, in_done, xfer_timeout, toggle
// Option : USB_EP_STALL_EN adds ep_halt / clr_halt and STALL responses.
module usb_ep_proto_ctrl
  import usb_proto_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024,
  parameter int TMR_W       = 11
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [2:0] rx_packet,
  input  logic       rx_data_ready,
  input  logic       rx_error,
  input  logic [6:0] buffer_ocup,
  input  logic       in_data_valid,
  input  logic       tx_transfer_active,
`ifdef USB_EP_STALL_EN
  input  logic       ep_halt,
  input  logic       clr_halt,
`endif
  output logic [2:0] tx_packet,
  output logic       tx_start,
  output logic       d_mode,
  output logic       flush_req,
  output logic       rx_ok,
  output logic       in_done,
  output logic       xfer_timeout,
  output logic       toggle
);
  state_t r_state;
  logic r_rdy, r_err, r_room, r_seen;
  logic w_ev, w_err, w_done, w_clr, w_en, w_halt;
  assign w_err = rx_error & ~r_err;
  assign w_ev  = rx_data_ready & ~r_rdy & ~w_err;
`ifdef USB_EP_STALL_EN
  assign w_halt = ep_halt;
`else
  assign w_halt = 1'b0;
`endif
  // Timer is held at zero until the phase that uses it starts; in TX_BUSY it only
  // runs while waiting for TX to begin, so IN_WAIT starts from zero.
  assign w_clr = (r_state == ST_IDLE) || (r_state == ST_HS_SEND) || (r_state == ST_IN_SEND) ||
                 ((r_state == ST_TX_BUSY) && r_seen);
  assign w_en  = (r_state == ST_OUT_WAIT) || (r_state == ST_IN_WAIT) || (r_state == ST_TX_BUSY);
  usb_timeout_counter #(.TIMEOUT_CYC(TIMEOUT_CYC), .TMR_W(TMR_W)) u_tmr (
    .clk(clk), .n_rst(n_rst), .i_clr(w_clr), .i_en(w_en), .o_done(w_done)
  );
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state      <= ST_IDLE;
      r_rdy        <= 1'b0;
      r_err        <= 1'b0;
      r_room       <= 1'b0;
      r_seen       <= 1'b0;
      tx_packet    <= PID_NONE;
      tx_start     <= 1'b0;
      d_mode       <= 1'b0;
      flush_req    <= 1'b0;
      rx_ok        <= 1'b0;
      in_done      <= 1'b0;
      xfer_timeout <= 1'b0;
      toggle       <= 1'b0;
    end else begin
      r_rdy        <= rx_data_ready;
      r_err        <= rx_error;
      tx_start     <= 1'b0;
      flush_req    <= 1'b0;
      rx_ok        <= 1'b0;
      in_done      <= 1'b0;
      xfer_timeout <= 1'b0;
      case (r_state)
        ST_IDLE:
          if (w_ev && rx_packet == PID_OUT) begin
            r_room  <= buffer_ocup == 7'd0;
            r_state <= ST_OUT_WAIT;
          end else if (w_ev && rx_packet == PID_IN) begin
            tx_packet <= w_halt ? PID_STALL : in_data_valid ? (toggle ? PID_DATA1 : PID_DATA0) : PID_NAK;
            r_state   <= (!w_halt && in_data_valid) ? ST_IN_SEND : ST_HS_SEND;
          end
        ST_OUT_WAIT:
          if (w_err) begin
            flush_req <= 1'b1;
            r_state   <= ST_IDLE;
          end else if (w_ev && is_data(rx_packet)) begin
            r_state <= ST_HS_SEND;
            if (w_halt) begin
              tx_packet <= PID_STALL;
              flush_req <= 1'b1;
            end else if (!r_room) begin
              tx_packet <= PID_NAK;
              flush_req <= 1'b1;
            end else if ((rx_packet == PID_DATA1) != toggle) begin
              tx_packet <= PID_ACK;
              flush_req <= 1'b1;
            end else begin
              tx_packet <= PID_ACK;
              rx_ok     <= 1'b1;
              toggle    <= ~toggle;
            end
          end else if (w_ev) r_state <= ST_IDLE;
          else if (w_done) begin
            xfer_timeout <= 1'b1;
            r_state      <= ST_IDLE;
          end
        ST_HS_SEND, ST_IN_SEND: begin
          tx_start <= 1'b1;
          d_mode   <= 1'b1;
          r_seen   <= 1'b0;
          r_state  <= ST_TX_BUSY;
        end
        ST_TX_BUSY:
          if (!r_seen) begin
            if (tx_transfer_active) r_seen <= 1'b1;
            else if (w_done) begin
              xfer_timeout <= 1'b1;
              d_mode       <= 1'b0;
              r_state      <= ST_IDLE;
            end
          end else if (!tx_transfer_active) begin
            d_mode  <= 1'b0;
            r_state <= is_data(tx_packet) ? ST_IN_WAIT : ST_IDLE;
          end
        ST_IN_WAIT:
          if (w_ev && rx_packet == PID_ACK) begin
            toggle  <= ~toggle;
            in_done <= 1'b1;
            r_state <= ST_IDLE;
          end else if (w_ev || w_err) r_state <= ST_IDLE;
          else if (w_done) begin
            xfer_timeout <= 1'b1;
            r_state      <= ST_IDLE;
          end
        default: r_state <= ST_IDLE;
      endcase
`ifdef USB_EP_STALL_EN
      if (clr_halt) toggle <= 1'b0;
`endif
    end
  end
endmodule

// File: tb/tb_usb_ep_proto_ctrl.sv
// tb_usb_ep_proto_ctrl: directed self-checking bench for usb_ep_proto_ctrl.
module tb_usb_ep_proto_ctrl;
  localparam logic [2:0] P_NONE = 3'd0, P_OUT = 3'd1, P_IN = 3'd2, P_D0 = 3'd3, P_D1 = 3'd4,
                         P_ACK = 3'd5, P_NAK = 3'd6;
  logic clk = 1'b0, n_rst = 1'b0;
  logic [2:0] rx_packet = 3'd0;
  logic rx_data_ready = 1'b0, rx_error = 1'b0, in_data_valid = 1'b0, tx_transfer_active = 1'b0;
  logic [6:0] buffer_ocup = 7'd0;
  logic [2:0] tx_packet;
  logic tx_start, d_mode, flush_req, rx_ok, in_done, xfer_timeout, toggle;
`ifdef USB_EP_STALL_EN
  logic ep_halt = 1'b0, clr_halt = 1'b0;
`endif
  int checks = 0, errors = 0;
  int n_start = 0, n_flush = 0, n_rxok = 0, n_done = 0;

  usb_ep_proto_ctrl dut (
    .clk(clk), .n_rst(n_rst), .rx_packet(rx_packet), .rx_data_ready(rx_data_ready),
    .rx_error(rx_error), .buffer_ocup(buffer_ocup), .in_data_valid(in_data_valid),
    .tx_transfer_active(tx_transfer_active),
`ifdef USB_EP_STALL_EN
    .ep_halt(ep_halt), .clr_halt(clr_halt),
`endif
    .tx_packet(tx_packet), .tx_start(tx_start), .d_mode(d_mode), .flush_req(flush_req),
    .rx_ok(rx_ok), .in_done(in_done), .xfer_timeout(xfer_timeout), .toggle(toggle)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (tx_start) n_start++;
    if (flush_req) n_flush++;
    if (rx_ok) n_rxok++;
    if (in_done) n_done++;
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_pkt(input logic [2:0] pid);
    rx_packet = pid;
    rx_data_ready = 1'b1;
    tick(1);
    rx_data_ready = 1'b0;
  endtask

  task automatic tx_run(output logic [2:0] pkt);
    int k = 0;
    while (!tx_start && k < 10) begin
      tick(1);
      k++;
    end
    checks++;
    if (tx_start !== 1'b1) begin
      errors++;
      $display("FAIL tx_start_wait: tx_start=%b required 1 within 10 cycles", tx_start);
    end
    checks++;
    if (d_mode !== 1'b1) begin
      errors++;
      $display("FAIL d_mode_at_start: got %b required 1", d_mode);
    end
    pkt = tx_packet;
    tx_transfer_active = 1'b1;
    tick(3);
    checks++;
    if (d_mode !== 1'b1 || tx_packet !== pkt) begin
      errors++;
      $display("FAIL tx_hold: d_mode=%b tx_packet=%0d required 1 and %0d", d_mode, tx_packet, pkt);
    end
    tx_transfer_active = 1'b0;
    tick(1);
    checks++;
    if (d_mode !== 1'b0) begin
      errors++;
      $display("FAIL d_mode_release: got %b required 0", d_mode);
    end
  endtask

  task automatic test_reset;
    checks++;
    if ({tx_packet, tx_start, d_mode, flush_req, rx_ok, in_done, xfer_timeout, toggle} !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: outputs=%b required all 0",
               {tx_packet, tx_start, d_mode, flush_req, rx_ok, in_done, xfer_timeout, toggle});
    end
  endtask

  task automatic test_out_ack;
    int s0 = n_start, f0 = n_flush;
    logic [2:0] p;
    buffer_ocup = 7'd0;
    send_pkt(P_OUT);
    tick(2);
    checks++;
    if (d_mode !== 1'b0) begin
      errors++;
      $display("FAIL out_wait_dmode: got %b required 0", d_mode);
    end
    send_pkt(P_D0);
    checks++;
    if (rx_ok !== 1'b1 || toggle !== 1'b1 || tx_packet !== P_ACK) begin
      errors++;
      $display("FAIL out_ack: rx_ok=%b toggle=%b tx_packet=%0d required 1 1 %0d", rx_ok, toggle, tx_packet, P_ACK);
    end
    tx_run(p);
    tick(2);
    checks++;
    if (n_start - s0 != 1 || n_flush - f0 != 0 || p !== P_ACK) begin
      errors++;
      $display("FAIL out_ack_counts: starts=%0d flushes=%0d pkt=%0d required 1 0 %0d", n_start - s0, n_flush - f0, p, P_ACK);
    end
  endtask

  task automatic test_toggle_mismatch;
    int r0 = n_rxok, f0 = n_flush;
    logic [2:0] p;
    send_pkt(P_OUT);
    tick(2);
    send_pkt(P_D0);
    tx_run(p);
    tick(2);
    checks++;
    if (p !== P_ACK || n_flush - f0 != 1 || n_rxok - r0 != 0 || toggle !== 1'b1) begin
      errors++;
      $display("FAIL toggle_mismatch: pkt=%0d flushes=%0d rx_ok=%0d toggle=%b required %0d 1 0 1",
               p, n_flush - f0, n_rxok - r0, toggle, P_ACK);
    end
  endtask

  task automatic test_no_room;
    int r0 = n_rxok, f0 = n_flush;
    logic [2:0] p;
    buffer_ocup = 7'd12;
    send_pkt(P_OUT);
    tick(2);
    buffer_ocup = 7'd0;
    send_pkt(P_D1);
    tx_run(p);
    tick(2);
    checks++;
    if (p !== P_NAK || n_flush - f0 != 1 || n_rxok - r0 != 0 || toggle !== 1'b1) begin
      errors++;
      $display("FAIL no_room: pkt=%0d flushes=%0d rx_ok=%0d toggle=%b required %0d 1 0 1",
               p, n_flush - f0, n_rxok - r0, toggle, P_NAK);
    end
  endtask

  task automatic test_in_data;
    logic [2:0] p;
    in_data_valid = 1'b1;
    send_pkt(P_IN);
    tx_run(p);
    checks++;
    if (p !== P_D1) begin
      errors++;
      $display("FAIL in_data1: pkt=%0d required %0d", p, P_D1);
    end
    tick(3);
    send_pkt(P_ACK);
    checks++;
    if (in_done !== 1'b1 || toggle !== 1'b0) begin
      errors++;
      $display("FAIL in_ack1: in_done=%b toggle=%b required 1 0", in_done, toggle);
    end
    tick(2);
    send_pkt(P_IN);
    tx_run(p);
    checks++;
    if (p !== P_D0) begin
      errors++;
      $display("FAIL in_data0: pkt=%0d required %0d", p, P_D0);
    end
    tick(1);
    send_pkt(P_ACK);
    checks++;
    if (in_done !== 1'b1 || toggle !== 1'b1) begin
      errors++;
      $display("FAIL in_ack0: in_done=%b toggle=%b required 1 1", in_done, toggle);
    end
    tick(2);
  endtask

  task automatic test_in_timeout;
    int d0 = n_done;
    logic [2:0] p;
    in_data_valid = 1'b1;
    send_pkt(P_IN);
    tx_run(p);
    tick(1023);
    checks++;
    if (xfer_timeout !== 1'b0) begin
      errors++;
      $display("FAIL in_timeout_early: xfer_timeout=%b required 0", xfer_timeout);
    end
    tick(1);
    checks++;
    if (xfer_timeout !== 1'b1 || toggle !== 1'b1 || n_done - d0 != 0) begin
      errors++;
      $display("FAIL in_timeout: xfer_timeout=%b toggle=%b in_done=%0d required 1 1 0", xfer_timeout, toggle, n_done - d0);
    end
    tick(2);
  endtask

  task automatic test_in_nak;
    int d0 = n_done;
    logic [2:0] p;
    in_data_valid = 1'b0;
    send_pkt(P_IN);
    tx_run(p);
    tick(1);
    send_pkt(P_ACK);
    tick(2);
    checks++;
    if (p !== P_NAK || n_done - d0 != 0 || toggle !== 1'b1) begin
      errors++;
      $display("FAIL in_nak: pkt=%0d in_done=%0d toggle=%b required %0d 0 1", p, n_done - d0, toggle, P_NAK);
    end
  endtask

  task automatic test_out_timeout;
    send_pkt(P_OUT);
    tick(1023);
    checks++;
    if (xfer_timeout !== 1'b0) begin
      errors++;
      $display("FAIL out_timeout_early: xfer_timeout=%b required 0", xfer_timeout);
    end
    tick(1);
    checks++;
    if (xfer_timeout !== 1'b1 || d_mode !== 1'b0) begin
      errors++;
      $display("FAIL out_timeout: xfer_timeout=%b d_mode=%b required 1 0", xfer_timeout, d_mode);
    end
    tick(1);
    checks++;
    if (xfer_timeout !== 1'b0) begin
      errors++;
      $display("FAIL out_timeout_pulse: xfer_timeout=%b required 0", xfer_timeout);
    end
  endtask

  task automatic test_err_same_cycle;
    int s0 = n_start, r0 = n_rxok;
    buffer_ocup = 7'd0;
    send_pkt(P_OUT);
    tick(2);
    rx_packet = P_D1;
    rx_data_ready = 1'b1;
    rx_error = 1'b1;
    tick(1);
    checks++;
    if (flush_req !== 1'b1) begin
      errors++;
      $display("FAIL err_flush: flush_req=%b required 1", flush_req);
    end
    rx_data_ready = 1'b0;
    rx_error = 1'b0;
    tick(2);
    send_pkt(P_D1);
    tick(5);
    checks++;
    if (n_start - s0 != 0 || n_rxok - r0 != 0 || toggle !== 1'b1) begin
      errors++;
      $display("FAIL err_idle: starts=%0d rx_ok=%0d toggle=%b required 0 0 1", n_start - s0, n_rxok - r0, toggle);
    end
  endtask

  task automatic test_reset_mid;
    in_data_valid = 1'b1;
    send_pkt(P_IN);
    tick(2);
    tx_transfer_active = 1'b1;
    tick(2);
    checks++;
    if (d_mode !== 1'b1) begin
      errors++;
      $display("FAIL mid_tx_dmode: d_mode=%b required 1", d_mode);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({tx_packet, tx_start, d_mode, flush_req, rx_ok, in_done, xfer_timeout, toggle} !== {P_NONE, 7'd0}) begin
      errors++;
      $display("FAIL mid_reset: outputs=%b required all 0",
               {tx_packet, tx_start, d_mode, flush_req, rx_ok, in_done, xfer_timeout, toggle});
    end
    tx_transfer_active = 1'b0;
    tick(2);
    n_rst = 1'b1;
    tick(2);
  endtask

  initial begin
    tick(2);
    test_reset;
    n_rst = 1'b1;
    tick(2);
    test_out_ack;
    test_toggle_mismatch;
    test_no_room;
    test_in_data;
    test_in_timeout;
    test_in_nak;
    test_out_timeout;
    test_err_same_cycle;
    test_reset_mid;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
